// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shifter family: state encoding,
// counter sizing and the default idle level of the serial output.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_shift_state_t;

  localparam logic SPI_IDLE_LEVEL_DEFAULT = 1'b0;

  // The counter holds WIDTH itself, so it needs one value more than WIDTH-1.
  function automatic int spi_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// Controller-side bus of spi_shifter: load request, SPI edge strobes,
// serial lines and completion status.
interface spi_shifter_if #(
  parameter int WIDTH = 8
);
  // Handshake: load is taken on a rising clk edge only while busy=0; a load
  // seen while busy=1 is dropped, so busy acts as not-ready and the requester
  // holds or re-issues load until busy=0. done pulses for one cycle per word.
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             sample_en;
  logic             shift_en;
  logic             s_in;
  logic             s_out;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output load, data_in, sample_en, shift_en, s_in,
    input  s_out, data_out, busy, done
  );

  modport slave (
    input  load, data_in, sample_en, shift_en, s_in,
    output s_out, data_out, busy, done
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so it can also
// serve the SPI clock generator.
module spi_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          dec_en,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/spi_shifter.sv
// Full-duplex SPI data shifter: WIDTH-bit word, MSB- or LSB-first, paced by
// sample/shift strobes. Optional SPI_SHIFT_LOOPBACK_EN adds a loopback port.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = SPI_IDLE_LEVEL_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                            loopback,
`endif
  spi_shifter_if.slave                    bus,
  output spi_shift_state_t                dbg_state,
  output logic [spi_cnt_width(WIDTH)-1:0] dbg_count
);

  localparam int            CW       = spi_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sample_q, sample_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    count;
  logic             cnt_zero;
  logic             accept;
  logic             shift_go;
  logic             last_shift;
  logic             s_out_w;
  logic             serial_in;
  logic             in_bit;
  logic [WIDTH-1:0] sr_shifted;

  assign accept     = (state_q == ST_IDLE) && bus.load;
  assign shift_go   = (state_q == ST_SHIFT) && bus.shift_en && !cnt_zero;
  assign last_shift = shift_go && (count == CW'(1));

  assign s_out_w = (state_q == ST_SHIFT) ? (LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1])
                                         : IDLE_LEVEL;

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign serial_in = loopback ? s_out_w : bus.s_in;
`else
  assign serial_in = bus.s_in;
`endif

  // A coincident sample strobe feeds the live input straight into the shift.
  assign in_bit     = bus.sample_en ? serial_in : sample_q;
  assign sr_shifted = LSB_FIRST ? {in_bit, sr_q[WIDTH-1:1]}
                                : {sr_q[WIDTH-2:0], in_bit};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    sample_d   = sample_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          sr_d    = bus.data_in;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.sample_en) begin
          sample_d = serial_in;
        end
        if (shift_go) begin
          sr_d = sr_shifted;
        end
        if (last_shift) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = sr_shifted;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      sample_q   <= 1'b0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sample_q   <= sample_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  spi_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept),
    .ld_val (CNT_LOAD),
    .dec_en (shift_go),
    .count  (count),
    .zero   (cnt_zero)
  );

  assign bus.s_out    = s_out_w;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = spi_shift_state_t'(state_q);
  assign dbg_count    = count;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: MSB-first and LSB-first instances, plus a
// 16-bit loopback instance when SPI_SHIFT_LOOPBACK_EN is defined.
module tb_spi_shifter;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] tx;
  logic [7:0] rx;

  spi_shifter_if #(.WIDTH(8)) m_if ();
  spi_shifter_if #(.WIDTH(8)) l_if ();
  spi_shift_state_t m_state, l_state;
  logic [3:0]       m_count, l_count;

  spi_shifter #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk       (clk),
    .rst       (rst),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback  (1'b0),
`endif
    .bus       (m_if),
    .dbg_state (m_state),
    .dbg_count (m_count)
  );

  spi_shifter #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk       (clk),
    .rst       (rst),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback  (1'b0),
`endif
    .bus       (l_if),
    .dbg_state (l_state),
    .dbg_count (l_count)
  );

`ifdef SPI_SHIFT_LOOPBACK_EN
  spi_shifter_if #(.WIDTH(16)) k_if ();
  spi_shift_state_t k_state;
  logic [4:0]       k_count;
  logic             k_loop;

  spi_shifter #(.WIDTH(16), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_loop (
    .clk       (clk),
    .rst       (rst),
    .loopback  (k_loop),
    .bus       (k_if),
    .dbg_state (k_state),
    .dbg_count (k_count)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_pair(input logic sin);
    m_if.s_in      = sin;
    m_if.sample_en = 1'b1;
    tick();
    m_if.sample_en = 1'b0;
    m_if.shift_en  = 1'b1;
    tick();
    m_if.shift_en  = 1'b0;
  endtask

  task automatic m_co(input logic sin);
    m_if.s_in      = sin;
    m_if.sample_en = 1'b1;
    m_if.shift_en  = 1'b1;
    tick();
    m_if.sample_en = 1'b0;
    m_if.shift_en  = 1'b0;
  endtask

  task automatic l_pair(input logic sin);
    l_if.s_in      = sin;
    l_if.sample_en = 1'b1;
    tick();
    l_if.sample_en = 1'b0;
    l_if.shift_en  = 1'b1;
    tick();
    l_if.shift_en  = 1'b0;
  endtask

  initial begin
    m_if.data_in = 8'h00; m_if.sample_en = 1'b0; m_if.s_in = 1'b0;
    l_if.data_in = 8'h00; l_if.sample_en = 1'b0; l_if.s_in = 1'b0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    k_if.load = 1'b0; k_if.data_in = 16'h0; k_if.sample_en = 1'b0;
    k_if.shift_en = 1'b0; k_if.s_in = 1'b0; k_loop = 1'b0;
`endif

    // Reset held for two cycles against load and shift_en.
    rst = 1'b0;
    m_if.load = 1'b1; m_if.shift_en = 1'b1;
    l_if.load = 1'b1; l_if.shift_en = 1'b1;
    tick();
    tick();
    check("rst_busy", m_if.busy, 1'b0);
    check("rst_done", m_if.done, 1'b0);
    check("rst_sout", m_if.s_out, 1'b0);
    check("rst_dout", m_if.data_out, 8'h00);
    check("rst_count", m_count, 4'd0);
    check("rst_state", m_state, IDLE);
    check("rst_lsb_sout_idle1", l_if.s_out, 1'b1);
    check("rst_lsb_busy", l_if.busy, 1'b0);
    check("rst_lsb_state", l_state, IDLE);
    rst = 1'b1;
    m_if.load = 1'b0; m_if.shift_en = 1'b0;
    l_if.load = 1'b0; l_if.shift_en = 1'b0;
    tick();

    // MSB-first: send 0xA5 while receiving 0x3C.
    tx = 8'hA5; rx = 8'h3C;
    m_if.data_in = tx; m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    check("msb_busy", m_if.busy, 1'b1);
    check("msb_count", m_count, 4'd8);
    check("msb_state", m_state, SHIFT);
    for (int i = 0; i < 8; i++) begin
      check("msb_sout", m_if.s_out, tx[7-i]);
      m_pair(rx[7-i]);
      check("msb_done", m_if.done, (i == 7));
      check("msb_busy_run", m_if.busy, (i != 7));
    end
    check("msb_dout", m_if.data_out, 8'h3C);
    tick();
    check("msb_done_pulse", m_if.done, 1'b0);

    // LSB-first: same words, bits in the other order.
    l_if.data_in = tx; l_if.load = 1'b1;
    tick();
    l_if.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_sout", l_if.s_out, tx[i]);
      l_pair(rx[i]);
      check("lsb_done", l_if.done, (i == 7));
    end
    check("lsb_dout", l_if.data_out, 8'h3C);
    tick();
    check("lsb_sout_idle", l_if.s_out, 1'b1);

    // A load while busy must not disturb the running word.
    tx = 8'h11;
    m_if.data_in = tx; m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_sout_pre", m_if.s_out, tx[7-i]);
      m_pair(1'b0);
    end
    m_if.data_in = 8'hFF; m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    check("busy_still", m_if.busy, 1'b1);
    check("busy_count", m_count, 4'd5);
    for (int i = 3; i < 8; i++) begin
      check("busy_sout_post", m_if.s_out, tx[7-i]);
      m_pair(1'b0);
    end
    check("busy_done", m_if.done, 1'b1);
    check("busy_dout", m_if.data_out, 8'h00);
    tick();

    // Coincident sample_en+shift_en capture the live s_in.
    rx = 8'h96;
    m_if.data_in = 8'h00; m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_co(rx[7-i]);
    end
    check("co_done", m_if.done, 1'b1);
    check("co_dout", m_if.data_out, 8'h96);
    tick();

    // load with shift_en in IDLE: load wins, no shift.
    rx = 8'hE7;
    m_if.data_in = 8'h5A; m_if.load = 1'b1; m_if.shift_en = 1'b1;
    tick();
    m_if.load = 1'b0; m_if.shift_en = 1'b0;
    check("ldsh_count", m_count, 4'd8);
    check("ldsh_sout", m_if.s_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      m_pair(rx[7-i]);
    end
    check("ldsh_done", m_if.done, 1'b1);
    check("ldsh_dout", m_if.data_out, 8'hE7);

    // Load in the cycle right after done starts the next word.
    m_if.data_in = 8'h0F; m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    check("b2b_busy", m_if.busy, 1'b1);
    check("b2b_count", m_count, 4'd8);
    check("b2b_sout", m_if.s_out, 1'b0);

    // Abort mid-transfer with reset.
    for (int i = 0; i < 4; i++) begin
      m_pair(1'b1);
    end
    check("abort_count_pre", m_count, 4'd4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", m_if.busy, 1'b0);
    check("abort_done", m_if.done, 1'b0);
    check("abort_dout", m_if.data_out, 8'h00);
    check("abort_count", m_count, 4'd0);
    tick();
    check("abort_no_done", m_if.done, 1'b0);

`ifdef SPI_SHIFT_LOOPBACK_EN
    // Loopback rotates the word through itself, ignoring s_in.
    k_loop = 1'b1;
    k_if.data_in = 16'hBEEF; k_if.load = 1'b1;
    tick();
    k_if.load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      k_if.s_in = 1'b0;
      k_if.sample_en = 1'b1;
      tick();
      k_if.sample_en = 1'b0;
      k_if.shift_en = 1'b1;
      tick();
      k_if.shift_en = 1'b0;
    end
    check("loop_done", k_if.done, 1'b1);
    check("loop_dout", k_if.data_out, 16'hBEEF);
`endif

    if (errors != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", errors, checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_shifter.md
Name: spi_shifter

Overview:
Parametrised full-duplex SPI data shifter, successor to the fixed 8-bit transmit-only shift register in the SPI LCD controller. Loads a WIDTH-bit word, serialises it MSB- or LSB-first under strobes from the SPI clock generator, and captures the serial input into a receive word. A bit counter drives busy/done flags, so the controller FSM no longer counts bits.

Parameters:
WIDTH, 8, word length in bits (2..32)
LSB_FIRST, 0, 0 = MSB transmitted/received first, 1 = LSB first
IDLE_LEVEL, 0, s_out value while not busy and in reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
load  in  1  start request; accepted only when busy=0
data_in  in  WIDTH  word to transmit, sampled on accepted load
sample_en  in  1  one-cycle strobe: capture s_in (SPI sample edge)
shift_en  in  1  one-cycle strobe: advance shift register (SPI shift edge)
s_in  in  1  serial receive input (MISO)
s_out  out  1  serial transmit output (MOSI)
data_out  out  WIDTH  last fully received word
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (rst=0 at clk edge): shift reg=0, sample bit=0, counter=0, data_out=0, busy=0, done=0, s_out=IDLE_LEVEL, state IDLE. Overrides all other inputs.
- States: IDLE, SHIFT. There is no separate DONE state; done is a registered pulse.
- IDLE: load=1 -> shift reg<=data_in, counter<=WIDTH, busy<=1, state<=SHIFT. Strobes are ignored in IDLE. If load and shift_en arrive in the same cycle, load wins and no shift occurs.
- SHIFT:
  - s_out = shift reg[WIDTH-1], or [0] if LSB_FIRST.
  - sample_en=1 -> sample bit<=s_in.
  - shift_en=1 -> the register shifts toward the output end and the sample bit enters at the opposite end; counter decrements.
  - If sample_en and shift_en coincide, the shift inserts the live s_in, bypassing the stale sample bit.
- Last shift (counter 1->0): state<=IDLE, busy<=0, done<=1 for exactly one cycle, data_out<=post-shift register contents. data_out is updated only at this point.
- load while busy: ignored, with no error flag; the controller must wait for busy=0.
- load in the cycle immediately after done: accepted, giving back-to-back words with one idle cycle minimum.
- Reset asserted mid-transfer: aborts the transfer, no done pulse, data_out cleared.
- The counter is $clog2(WIDTH+1) bits wide and never wraps below 0.
- Latency: for WIDTH shift strobes, done rises on the clk edge after the WIDTH-th shift_en.

Optional Feature:
SPI_SHIFT_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the internal serial input is s_out instead of s_in, for self-test. s_out is still driven externally.
- Undefined: the port is absent and s_in is always used. No extra logic.

Decomposition:
- Shared package spi_pkg: spi_shift_state_t enum (IDLE, SHIFT), a function returning the counter width for WIDTH, IDLE_LEVEL default constant.
- One natural sub-module: spi_bit_counter (load value, decrement on enable, zero flag), reusable by the clock generator. The rest stays in spi_shifter.

Test Plan:
- Reset: rst=0 for 2 cycles with load=1, shift_en=1 -> busy=0, done=0, s_out=IDLE_LEVEL, data_out=0.
- MSB-first loop (WIDTH=8, LSB_FIRST=0): load 0xA5, s_in tied to a model returning 0x3C MSB-first, 8 sample/shift pairs -> s_out sequence 1,0,1,0,0,1,0,1; done pulses once after the 8th shift; data_out=0x3C; busy=0.
- LSB-first (LSB_FIRST=1): load 0xA5, same model sending 0x3C LSB-first -> s_out 1,0,1,0,0,1,0,1 read LSB-first; data_out=0x3C.
- Busy protection: load 0x11, after 3 shifts pulse load with 0xFF -> the transfer continues unchanged and s_out stays the remaining bits of 0x11.
- Simultaneous/boundary: coincident sample_en+shift_en with s_in=1 -> that bit is captured. load+shift_en in IDLE -> counter=8 with no shift. load in the cycle after done -> the new transfer starts.
- Abort and loopback: rst=0 after 4 shifts -> no done, data_out=0. With SPI_SHIFT_LOOPBACK_EN and loopback=1, WIDTH=16, load 0xBEEF -> data_out=0xBEEF.
